// File: rtl/pred_check_rx.sv
// Receive-side checker for a parity-predicting adder: registers each accepted word, flags
// parity mismatches, counts them (saturating) and halts intake once the error threshold is hit.
module pred_check_rx #(
    parameter int unsigned DW     = 3,
    parameter int unsigned CW     = 8,
    parameter int unsigned THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_par,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_err,
    input  logic          clear,
    output logic          err_sticky,
    output logic [CW-1:0] err_cnt,
    output logic          halted
);

    typedef enum logic [1:0] {StRun, StDegraded, StHalt} state_e;

    localparam logic [CW-1:0] CntMax = {CW{1'b1}};
    localparam logic [CW-1:0] Thresh = CW'(THRESH);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_base;
    logic          sticky_q, sticky_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;
    logic          accept;
    logic          mismatch;

    always_comb begin
        in_ready = !rst && (state_q != StHalt) && (!valid_q || out_ready);
        accept   = in_valid && in_ready;
        mismatch = ^{in_data, in_par};

        // Clear takes effect first so a coincident error is counted from zero.
        state_d  = clear ? StRun : state_q;
        cnt_base = clear ? '0 : cnt_q;
        sticky_d = clear ? 1'b0 : sticky_q;
        cnt_d    = cnt_base;

        if (accept && mismatch) begin
            cnt_d    = (cnt_base == CntMax) ? cnt_base : cnt_base + 1'b1;
            sticky_d = 1'b1;
            state_d  = (cnt_d >= Thresh) ? StHalt : StDegraded;
        end

        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data;
            err_d   = mismatch;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_err    = err_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
    assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_pred_check_rx.sv
// Directed bench for pred_check_rx: default instance plus CW=2/THRESH=3 and THRESH=1 instances.
module tb_pred_check_rx;

    logic       clk = 1'b0;
    logic       rst;

    // Instance A: defaults (DW=3, CW=8, THRESH=4)
    logic       a_in_valid, a_in_ready, a_in_par, a_out_valid, a_out_ready, a_out_err;
    logic       a_clear, a_sticky, a_halted;
    logic [2:0] a_in_data, a_out_data;
    logic [7:0] a_cnt;

    // Instances B (CW=2, THRESH=3) and C (THRESH=1) share one input set
    logic       b_in_valid, b_in_par, b_out_ready, b_clear;
    logic [2:0] b_in_data;
    logic       b_in_ready, b_out_valid, b_out_err, b_sticky, b_halted;
    logic [2:0] b_out_data;
    logic [1:0] b_cnt;
    logic       c_in_ready, c_out_valid, c_out_err, c_sticky, c_halted;
    logic [2:0] c_out_data;
    logic [7:0] c_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pred_check_rx u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_par(a_in_par), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err),
        .clear(a_clear), .err_sticky(a_sticky), .err_cnt(a_cnt), .halted(a_halted)
    );

    pred_check_rx #(.DW(3), .CW(2), .THRESH(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_par(b_in_par), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err),
        .clear(b_clear), .err_sticky(b_sticky), .err_cnt(b_cnt), .halted(b_halted)
    );

    pred_check_rx #(.DW(3), .CW(8), .THRESH(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(c_in_ready),
        .in_data(b_in_data), .in_par(b_in_par), .out_valid(c_out_valid),
        .out_ready(b_out_ready), .out_data(c_out_data), .out_err(c_out_err),
        .clear(b_clear), .err_sticky(c_sticky), .err_cnt(c_cnt), .halted(c_halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [2:0] d, input logic p);
        a_in_valid = v;
        a_in_data  = d;
        a_in_par   = p;
    endtask

    initial begin
        logic [2:0] w;
        rst = 1'b1;
        drive_a(1'b1, 3'b001, 1'b1);
        a_out_ready = 1'b1;
        a_clear     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 3'b000;
        b_in_par    = 1'b0;
        b_out_ready = 1'b1;
        b_clear     = 1'b0;
        #2;
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_out_data", 32'(a_out_data), 0);
        check("rst_cnt", 32'(a_cnt), 0);
        check("rst_halted", 32'(a_halted), 0);
        check("rst_in_ready", 32'(a_in_ready), 0);
        tick();
        check("rst_no_xfer", 32'(a_out_valid), 0);
        rst = 1'b0;

        // Two clean words, one cycle latency each
        drive_a(1'b1, 3'b101, 1'b0);
        tick();
        check("w1_valid", 32'(a_out_valid), 1);
        check("w1_data", 32'(a_out_data), 5);
        check("w1_err", 32'(a_out_err), 0);
        drive_a(1'b1, 3'b111, 1'b1);
        tick();
        check("w2_data", 32'(a_out_data), 7);
        check("w2_err", 32'(a_out_err), 0);
        drive_a(1'b0, 3'b000, 1'b0);
        tick();
        check("drain_valid", 32'(a_out_valid), 0);
        check("clean_cnt", 32'(a_cnt), 0);
        check("clean_sticky", 32'(a_sticky), 0);

        // First erroneous word -> DEGRADED
        drive_a(1'b1, 3'b011, 1'b1);
        tick();
        check("e1_err", 32'(a_out_err), 1);
        check("e1_sticky", 32'(a_sticky), 1);
        check("e1_cnt", 32'(a_cnt), 1);
        check("e1_halted", 32'(a_halted), 0);

        // Three more errors -> HALT after the fourth
        tick();
        tick();
        check("e3_halted", 32'(a_halted), 0);
        tick();
        check("e4_cnt", 32'(a_cnt), 4);
        check("e4_halted", 32'(a_halted), 1);
        check("e4_held", 32'(a_out_valid), 1);
        drive_a(1'b1, 3'b001, 1'b1);
        #1;
        check("halt_in_ready", 32'(a_in_ready), 0);
        tick();
        check("halt_drained", 32'(a_out_valid), 0);
        check("halt_cnt", 32'(a_cnt), 4);
        tick();
        check("halt_no_accept", 32'(a_out_valid), 0);

        drive_a(1'b0, 3'b000, 1'b0);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("clr_halted", 32'(a_halted), 0);
        check("clr_cnt", 32'(a_cnt), 0);
        check("clr_sticky", 32'(a_sticky), 0);

        // Backpressure: one word held for 5 cycles, then back-to-back
        a_out_ready = 1'b0;
        drive_a(1'b1, 3'b010, 1'b1);
        tick();
        check("bp_data0", 32'(a_out_data), 2);
        drive_a(1'b1, 3'b110, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", 32'(a_out_data), 2);
            check("bp_hold_valid", 32'(a_out_valid), 1);
            check("bp_in_ready", 32'(a_in_ready), 0);
        end
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(a_in_ready), 1);
        tick();
        check("bp_swap_data", 32'(a_out_data), 6);
        check("bp_swap_valid", 32'(a_out_valid), 1);
        for (int i = 1; i <= 3; i++) begin
            w = 3'(i);
            drive_a(1'b1, w, ^w);
            tick();
            check("b2b_data", 32'(a_out_data), 32'(i));
            check("b2b_valid", 32'(a_out_valid), 1);
            check("b2b_err", 32'(a_out_err), 0);
        end
        drive_a(1'b0, 3'b000, 1'b0);
        tick();
        check("b2b_drain", 32'(a_out_valid), 0);

        // Clear leaves a pending output word in place
        a_out_ready = 1'b0;
        drive_a(1'b1, 3'b100, 1'b1);
        tick();
        drive_a(1'b0, 3'b000, 1'b0);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("clr_keep_valid", 32'(a_out_valid), 1);
        check("clr_keep_data", 32'(a_out_data), 4);
        a_out_ready = 1'b1;
        tick();
        check("clr_keep_drain", 32'(a_out_valid), 0);

        // Clear coincident with an erroneous accept
        drive_a(1'b1, 3'b011, 1'b1);
        tick();
        tick();
        check("pre_clr_cnt", 32'(a_cnt), 2);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        drive_a(1'b0, 3'b000, 1'b0);
        check("clr_err_cnt", 32'(a_cnt), 1);
        check("clr_err_sticky", 32'(a_sticky), 1);
        check("clr_err_halted", 32'(a_halted), 0);
        check("clr_err_out", 32'(a_out_err), 1);
        tick();

        // Reset mid-stream clears outputs without a clock
        a_out_ready = 1'b0;
        drive_a(1'b1, 3'b101, 1'b0);
        tick();
        check("pre_rst_valid", 32'(a_out_valid), 1);
        a_out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(a_out_valid), 0);
        check("arst_data", 32'(a_out_data), 0);
        check("arst_err", 32'(a_out_err), 0);
        check("arst_cnt", 32'(a_cnt), 0);
        check("arst_sticky", 32'(a_sticky), 0);
        check("arst_in_ready", 32'(a_in_ready), 0);
        tick();
        check("arst_no_xfer", 32'(a_out_valid), 0);
        rst = 1'b0;
        tick();
        check("post_rst_accept", 32'(a_out_valid), 1);
        check("post_rst_data", 32'(a_out_data), 5);
        drive_a(1'b0, 3'b000, 1'b0);

        // B (CW=2, THRESH=3) and C (THRESH=1): five errors with a clear in between
        b_in_valid = 1'b1;
        b_in_data  = 3'b011;
        b_in_par   = 1'b1;
        tick();
        check("b_e1_cnt", 32'(b_cnt), 1);
        check("b_e1_halted", 32'(b_halted), 0);
        check("c_e1_halted", 32'(c_halted), 1);
        check("c_e1_cnt", 32'(c_cnt), 1);
        check("c_e1_sticky", 32'(c_sticky), 1);
        tick();
        check("b_e2_cnt", 32'(b_cnt), 2);
        check("c_halt_cnt", 32'(c_cnt), 1);
        b_in_valid = 1'b0;
        b_clear    = 1'b1;
        tick();
        b_clear = 1'b0;
        check("b_clr_cnt", 32'(b_cnt), 0);
        check("c_clr_halted", 32'(c_halted), 0);
        b_in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("b_sat_cnt", 32'(b_cnt), 32'(i));
        end
        check("b_halted", 32'(b_halted), 1);
        check("b_in_ready", 32'(b_in_ready), 0);
        tick();
        check("b_no_wrap", 32'(b_cnt), 3);
        b_in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish, expected finish before 50000");
        $fatal(1);
    end

endmodule

// File: doc/pred_check_rx.md
PRED_CHECK_RX -- requirements
Module: pred_check_rx

Interface
REQ-001 Parameter DW, default 3, data word width (adder sum width).
REQ-002 Parameter CW, default 8, error-counter width.
REQ-003 Parameter THRESH, default 4, error count that forces HALT; legal range 1..2^CW-1.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port in_valid  input  1  producer presents a word.
REQ-007 Port in_ready  output  1  block can accept a word.
REQ-008 Port in_data  input  DW  sum word from the parity-predicting adder.
REQ-009 Port in_par  input  1  predicted parity bit accompanying in_data.
REQ-010 Port out_valid  output  1  checked word available.
REQ-011 Port out_ready  input  1  consumer accepts the checked word.
REQ-012 Port out_data  output  DW  registered copy of the accepted in_data.
REQ-013 Port out_err  output  1  per-word mismatch flag for out_data.
REQ-014 Port clear  input  1  synchronous clear of counter, sticky flag and FSM.
REQ-015 Port err_sticky  output  1  set on the first mismatch; held until clear.
REQ-016 Port err_cnt  output  CW  saturating count of mismatching words accepted.
REQ-017 Port halted  output  1  high while the FSM is in HALT.

Function
REQ-018 Transfer in: in_valid & in_ready on a clock edge; transfer out: out_valid & out_ready.
REQ-019 Mismatch = XOR-reduction of in_data XOR in_par; a word is erroneous when this is 1.
REQ-020 Latency: an accepted word appears on out_valid/out_data/out_err on the next cycle.
REQ-021 Single output register: in_ready = (state != HALT) & (!out_valid | out_ready), combinational.
REQ-022 Output register holds out_data/out_err stable while out_valid & !out_ready.
REQ-023 Simultaneous output drain and input accept in one cycle keeps out_valid at 1 with the new word.
REQ-024 out_valid clears when the held word drains and no new word is accepted.
REQ-025 FSM states: RUN (no errors since clear), DEGRADED (1..THRESH-1 errors), HALT (count >= THRESH).
REQ-026 RUN -> DEGRADED on an erroneous accept when THRESH > 1; RUN -> HALT directly when THRESH = 1.
REQ-027 DEGRADED -> HALT on the accept that brings err_cnt to THRESH.
REQ-028 HALT: in_ready = 0; a word already in the output register still drains normally.
REQ-029 Any state -> RUN on clear; err_cnt -> 0, err_sticky -> 0.
REQ-030 Clear and erroneous accept in the same cycle: clear applies first, then the error is counted (err_cnt = 1, err_sticky = 1, state DEGRADED, or HALT if THRESH = 1).
REQ-031 err_cnt increments by 1 per erroneous accept and saturates at 2^CW-1; it never wraps.
REQ-032 Clear does not flush the output register; pending out_valid data is preserved.
REQ-033 halted = 1 exactly when state is HALT.

Reset
REQ-034 On rst high, immediately and without a clock: out_valid = 0, out_data = 0, out_err = 0, err_sticky = 0, err_cnt = 0, state RUN, halted = 0.
REQ-035 Reset asserted mid-transfer discards the held word; no transfer completes while rst is high.
REQ-036 in_ready = 0 while rst is high; first accept is possible on the first edge after rst is deasserted.

Verification
REQ-037 Words 3'b101/par 0, 3'b111/par 1, out_ready = 1 -> two outputs one cycle after each accept, out_err = 0,0, err_cnt = 0, state RUN.
REQ-038 Word 3'b011/par 1 -> out_err = 1, err_sticky = 1, err_cnt = 1, state DEGRADED.
REQ-039 THRESH = 4, four erroneous words -> halted = 1 after the fourth; in_ready = 0; fifth word not accepted; last word still drains.
REQ-040 out_ready held 0 for 5 cycles with in_valid = 1 -> out_data stable, in_ready = 0, exactly one word held; release -> back-to-back throughput of 1 word/cycle.
REQ-041 CW = 2, THRESH = 3, clear pulsed before HALT each time, 5 errors -> err_cnt saturates at 3, never 0 from wrap.
REQ-042 Clear coincident with an erroneous accept -> err_cnt = 1, err_sticky = 1, DEGRADED; rst mid-stream -> all outputs 0 asynchronously.
